// File: rtl/tetris_pkg.sv
// Shared types and constants for the piece dispenser: piece codes, bag
// geometry, queue geometry, request FSM states and a circular index helper.
package tetris_pkg;

  localparam int NPIECES = 7;
  localparam int PW      = 3;
  localparam int BAG_W   = NPIECES * PW;
  localparam int QDEPTH  = 2 * NPIECES;
  localparam int CW      = 4;

  typedef logic [PW-1:0] piece_t;

  typedef enum logic [PW-1:0] {
    PIECE_I    = 3'd0,
    PIECE_O    = 3'd1,
    PIECE_T    = 3'd2,
    PIECE_S    = 3'd3,
    PIECE_Z    = 3'd4,
    PIECE_J    = 3'd5,
    PIECE_L    = 3'd6,
    PIECE_NONE = 3'd7
  } piece_code_t;

  typedef enum logic {
    WAIT_LOW = 1'b0,
    REQ      = 1'b1
  } req_state_t;

  // Advance a queue index by inc, wrapping at QDEPTH. Both operands are
  // below QDEPTH+1, so one conditional subtract is enough.
  function automatic logic [CW-1:0] qidx_add(input logic [CW-1:0] ptr,
                                             input logic [CW-1:0] inc);
    logic [CW:0] sum;
    sum = {1'b0, ptr} + {1'b0, inc};
    if (sum >= 5'(QDEPTH)) begin
      sum = sum - 5'(QDEPTH);
    end
    return sum[CW-1:0];
  endfunction

endpackage

// File: rtl/piece_queue.sv
// 14-entry circular piece store: 7-wide push of a whole bag at the tail,
// 1-wide pop at the head, occupancy count. With PIECE_PREVIEW_EN defined the
// raw storage and head pointer are exported for the preview mux.
module piece_queue
  import tetris_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_push,
  input  logic [BAG_W-1:0] i_bag,
  input  logic           i_pop,
  output piece_t         o_head_piece,
  output logic [CW-1:0]  o_count
`ifdef PIECE_PREVIEW_EN
  ,
  output logic [CW-1:0]  o_head,
  output logic [QDEPTH*PW-1:0] o_mem
`endif
);

  piece_t        r_mem [QDEPTH];
  logic [CW-1:0] r_head;
  logic [CW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          w_pop;

  // A pop on an empty queue is dropped so the head never runs ahead.
  assign w_pop = i_pop && (r_count != '0);

  // Bag slots land at tail, tail+1, ... in slot order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < QDEPTH; k++) begin
        r_mem[k] <= '0;
      end
    end else if (i_push) begin
      for (int k = 0; k < NPIECES; k++) begin
        r_mem[qidx_add(r_tail, 4'(k))] <= i_bag[k*PW +: PW];
      end
    end
  end

  // Pointer and occupancy update; push and pop may coincide.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) begin
        r_head <= qidx_add(r_head, 4'd1);
      end
      if (i_push) begin
        r_tail <= qidx_add(r_tail, 4'(NPIECES));
      end
      r_count <= r_count + (i_push ? 4'(NPIECES) : 4'd0) - (w_pop ? 4'd1 : 4'd0);
    end
  end

  assign o_head_piece = r_mem[r_head];
  assign o_count      = r_count;

`ifdef PIECE_PREVIEW_EN
  assign o_head = r_head;

  // Flatten storage for the preview mux in the parent.
  always_comb begin
    o_mem = '0;
    for (int k = 0; k < QDEPTH; k++) begin
      o_mem[k*PW +: PW] = r_mem[k];
    end
  end
`endif

  // The requester only latches at count<=7, so the queue can never overfill.
  a_no_overflow : assert property (@(posedge i_clk) disable iff (i_rst)
    r_count <= 4'(QDEPTH));

endmodule

// File: rtl/piece_dispenser.sv
// Consumer side of the randombag newbag/ready/pieces handshake. Requests a
// bag whenever at most 7 pieces remain, latches each bag into piece_queue,
// and serves pieces over piece_valid/take. bag_err flags any latched code 7.
// Optional macro PIECE_PREVIEW_EN adds the preview port showing the
// PREVIEW_DEPTH entries that follow the head.
module piece_dispenser
  import tetris_pkg::*;
`ifdef PIECE_PREVIEW_EN
#(
  parameter int PREVIEW_DEPTH = 3
)
`endif
(
  input  logic             clk,
  input  logic             reset,
  output logic             newbag,
  input  logic             ready,
  input  logic [BAG_W-1:0] pieces,
  output logic             piece_valid,
  output logic [PW-1:0]    piece,
  input  logic             take,
  output logic [CW-1:0]    count,
  output logic             bag_err
`ifdef PIECE_PREVIEW_EN
  ,
  output logic [PW*PREVIEW_DEPTH-1:0] preview
`endif
);

  req_state_t    r_state;
  logic          r_newbag;
  logic          r_bag_err;
  logic          w_push;
  logic          w_pop;
  logic          w_slot_bad;
  logic [CW-1:0] w_count;
  piece_t        w_head_piece;
`ifdef PIECE_PREVIEW_EN
  logic [CW-1:0]        w_head;
  logic [QDEPTH*PW-1:0] w_mem;
`endif

  // Latch exactly once: only while requesting and the bag is flagged ready.
  assign w_push = (r_state == REQ) && ready;
  assign w_pop  = take && piece_valid;

  piece_queue u_queue (
    .i_clk        (clk),
    .i_rst        (reset),
    .i_push       (w_push),
    .i_bag        (pieces),
    .i_pop        (w_pop),
    .o_head_piece (w_head_piece),
    .o_count      (w_count)
`ifdef PIECE_PREVIEW_EN
    ,
    .o_head       (w_head),
    .o_mem        (w_mem)
`endif
  );

  // Request FSM: wait for ready low and room for a bag, then hold newbag
  // until the bag is sampled. Waiting for ready low also discards a bag
  // left over from before a reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= WAIT_LOW;
      r_newbag <= 1'b0;
    end else begin
      case (r_state)
        WAIT_LOW: begin
          if (!ready && (w_count <= 4'(NPIECES))) begin
            r_state  <= REQ;
            r_newbag <= 1'b1;
          end
        end
        REQ: begin
          if (ready) begin
            r_state  <= WAIT_LOW;
            r_newbag <= 1'b0;
          end
        end
        default: begin
          r_state  <= WAIT_LOW;
          r_newbag <= 1'b0;
        end
      endcase
    end
  end

  // Detect an invalid code in any slot of the incoming bag.
  always_comb begin
    w_slot_bad = 1'b0;
    for (int k = 0; k < NPIECES; k++) begin
      if (pieces[k*PW +: PW] == PIECE_NONE) begin
        w_slot_bad = 1'b1;
      end
    end
  end

  // Sticky error flag, set when a bag with an invalid code is latched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bag_err <= 1'b0;
    end else if (w_push && w_slot_bad) begin
      r_bag_err <= 1'b1;
    end
  end

  assign newbag      = r_newbag;
  assign bag_err     = r_bag_err;
  assign count       = w_count;
  assign piece_valid = (w_count != '0);
  assign piece       = w_head_piece;

`ifdef PIECE_PREVIEW_EN
  // Entries behind the head; anything past the queued pieces reads zero.
  always_comb begin
    logic [CW-1:0] w_idx;
    w_idx   = '0;
    preview = '0;
    for (int i = 0; i < PREVIEW_DEPTH; i++) begin
      w_idx = qidx_add(w_head, 4'(i + 1));
      if (5'(i + 1) < {1'b0, w_count}) begin
        preview[i*PW +: PW] = w_mem[w_idx*PW +: PW];
      end
    end
  end
`endif

endmodule

// File: tb/tb_piece_dispenser.sv
// Scoreboard bench for piece_dispenser: a queue model receives every bag the
// dispenser should latch and releases a piece on every accepted take; DUT
// outputs are compared against it on the falling clock edge.
module tb_piece_dispenser;
  import tetris_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        newbag;
  logic        ready;
  logic [20:0] pieces;
  logic        piece_valid;
  logic [2:0]  piece;
  logic        take;
  logic [3:0]  count;
  logic        bag_err;
`ifdef PIECE_PREVIEW_EN
  logic [8:0]  preview;
`endif

  always #5 clk = ~clk;

  piece_dispenser dut (
    .clk         (clk),
    .reset       (reset),
    .newbag      (newbag),
    .ready       (ready),
    .pieces      (pieces),
    .piece_valid (piece_valid),
    .piece       (piece),
    .take        (take),
    .count       (count),
    .bag_err     (bag_err)
`ifdef PIECE_PREVIEW_EN
    ,
    .preview     (preview)
`endif
  );

  int n_vec  = 0;
  int n_miss = 0;

  logic [2:0] exp_q[$];
  bit         m_req;
  bit         m_err;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [20:0] mk_bag(input logic [2:0] s0, input logic [2:0] s1,
                                         input logic [2:0] s2, input logic [2:0] s3,
                                         input logic [2:0] s4, input logic [2:0] s5,
                                         input logic [2:0] s6);
    return {s6, s5, s4, s3, s2, s1, s0};
  endfunction

  function automatic logic [20:0] rnd_bag();
    logic [20:0] b;
    for (int k = 0; k < 7; k++) begin
      b[3*k +: 3] = 3'($urandom_range(0, 6));
    end
    return b;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_req = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic check_outputs();
    int sz;
    sz = exp_q.size();
    check_eq("newbag", newbag, m_req);
    check_eq("piece_valid", piece_valid, (sz != 0));
    check_eq("count", count, sz);
    check_eq("bag_err", bag_err, m_err);
    if (sz != 0) begin
      check_eq("piece", piece, exp_q[0]);
    end
`ifdef PIECE_PREVIEW_EN
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("preview%0d", i), preview[3*i +: 3],
               (i + 1 < sz) ? int'(exp_q[i+1]) : 0);
    end
`endif
  endtask

  // One clock: update the model with the inputs present at the rising edge,
  // then compare on the falling edge.
  task automatic tick();
    int cnt;
    @(posedge clk);
    if (!reset) begin
      cnt = exp_q.size();
      if (take && cnt != 0) begin
        void'(exp_q.pop_front());
      end
      if (!m_req) begin
        if (!ready && cnt <= 7) m_req = 1'b1;
      end else if (ready) begin
        for (int k = 0; k < 7; k++) begin
          exp_q.push_back(pieces[3*k +: 3]);
          if (pieces[3*k +: 3] == 3'd7) m_err = 1'b1;
        end
        m_req = 1'b0;
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset  = 1'b1;
    ready  = 1'b0;
    take   = 1'b0;
    pieces = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    check_eq("rst_piece", piece, 0);

    // First request and fill
    reset = 1'b0;
    tick();
    check_eq("newbag_rise", newbag, 1);
    pieces = mk_bag(3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6);
    ready  = 1'b1;
    tick();
    check_eq("first_fill_count", count, 7);
    check_eq("first_fill_piece", piece, 0);
    tick();
    ready = 1'b0;
    tick();
    check_eq("rerequest", newbag, 1);

    // Second bag fills the queue
    pieces = mk_bag(3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0);
    ready  = 1'b1;
    tick();
    ready = 1'b0;
    ticks(3);
    check_eq("full_count", count, 14);
    check_eq("full_no_req", newbag, 0);

    // Drain all 14, then take on empty
    take = 1'b1;
    ticks(16);
    check_eq("drained", count, 0);
    take = 1'b0;

    // Latch and pop in the same cycle
    pieces = rnd_bag();
    ready  = 1'b1;
    tick();
    ready = 1'b0;
    tick();
    pieces = rnd_bag();
    ready  = 1'b1;
    take   = 1'b1;
    tick();
    check_eq("latch_pop_count", count, 13);
    ready = 1'b0;
    take  = 1'b0;
    tick();

    // ready held for several cycles latches one bag
    take = 1'b1;
    ticks(6);
    take = 1'b0;
    ticks(2);
    pieces = rnd_bag();
    ready  = 1'b1;
    ticks(5);
    ready = 1'b0;
    tick();
    check_eq("held_ready_count", count, 14);

    // Invalid code in slot 3
    take = 1'b1;
    ticks(7);
    take = 1'b0;
    ticks(2);
    pieces = mk_bag(3'd0, 3'd1, 3'd2, 3'd7, 3'd4, 3'd5, 3'd6);
    ready  = 1'b1;
    tick();
    ready = 1'b0;
    check_eq("bag_err_set", bag_err, 1);
    take = 1'b1;
    ticks(7);
    take = 1'b0;
    ticks(2);
    check_eq("bag_err_sticky", bag_err, 1);

    // Reset in the middle of a request
    check_eq("pre_reset_req", newbag, 1);
    #2 reset = 1'b1;
    #1;
    check_eq("async_newbag", newbag, 0);
    check_eq("async_count", count, 0);
    check_eq("async_bag_err", bag_err, 0);
    model_reset();
    @(negedge clk);
    pieces = rnd_bag();
    ready  = 1'b1;
    reset  = 1'b0;
    ticks(3);
    check_eq("stale_not_latched", count, 0);
    ready = 1'b0;
    tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check_eq("post_reset_fill", count, 7);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      take   = ($urandom_range(0, 2) != 0);
      ready  = newbag ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
      pieces = rnd_bag();
      tick();
    end
    take  = 1'b0;
    ready = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
